// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults, count width and threshold legality check for sync_fifo_param
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_CNT_WIDTH  = DEF_ADDR_WIDTH + 1;

  // Occupancy needs one extra bit so that DEPTH itself is representable.
  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction

  function automatic bit levels_legal(input int aw, input int af, input int ae);
    int depth;
    depth = 1 << aw;
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae < af);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x DATA_WIDTH register array, synchronous write, asynchronous read
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - FWFT synchronous FIFO; SYNC_FIFO_ERR_FLAG_EN enables sticky overflow/underflow
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = cnt_width(ADDR_WIDTH);
  localparam logic [CW-1:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT    = CW'(AE_LEVEL);

  if (!levels_legal(ADDR_WIDTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
    $error("sync_fifo_param: AF_LEVEL/AE_LEVEL out of range");
  end

  logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
  logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_ok, rd_ok;

  // Status is decoded from the count register only, never from wr/rd.
  assign full         = (count_q == DEPTH_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;

  assign wr_ok = wr & ~full & ~clr;
  assign rd_ok = rd & ~empty & ~clr;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    if (clr) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
    end else begin
      if (wr_ok) w_ptr_d = w_ptr_q + ADDR_WIDTH'(1);
      if (rd_ok) r_ptr_d = r_ptr_q + ADDR_WIDTH'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
    end
  end

`ifdef SYNC_FIFO_ERR_FLAG_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A read on empty is not an error when a same-cycle write lands in the FIFO.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr & full)        overflow_d  = 1'b1;
      if (rd & empty & ~wr) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_ok),
    .waddr_i (w_ptr_q),
    .wdata_i (wdata),
    .raddr_i (r_ptr_q),
    .rdata_o (rdata)
  );

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO with first-word-fall-through read, occupancy count, programmable almost-full/almost-empty thresholds and synchronous flush. It is the next-generation replacement for the fixed 16x8 FIFO used between UART/peripheral producers and consumers. Width, depth and thresholds are set per instance, and optional sticky overflow/underflow error flags are available for debug builds.

## Interface
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 4: pointer width; DEPTH = 2**ADDR_WIDTH entries.
- AF_LEVEL, 2**ADDR_WIDTH-2: almost_full asserts when count >= AF_LEVEL. Legal range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL. Legal range 0..AF_LEVEL-1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: asynchronous, active-high.
- clr  in  1  synchronous flush; empties the FIFO on the next edge.
- wr  in  1  write request.
- wdata  in  DATA_WIDTH  write data, sampled when a write is accepted.
- rd  in  1  read request; pops the current rdata word.
- rdata  out  DATA_WIDTH  head-of-queue word; valid only while empty=0.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was rejected (see Configuration).
- underflow  out  1  sticky: a read was rejected (see Configuration).

## Operation
- Reset values: w_ptr=0, r_ptr=0, count=0, full=0, empty=1, almost_full=0, almost_empty=1, overflow=0, underflow=0. rdata is don't-care while empty. Memory contents are not reset.
- Write accepted when wr=1 and full=0. wdata is stored at mem[w_ptr], and w_ptr increments modulo DEPTH.
- Read accepted when rd=1 and empty=0. r_ptr increments modulo DEPTH.
- Both accepted in the same cycle: both pointers advance and count is unchanged.
- Full with wr=1 and rd=1: the read is accepted and the write is dropped; count goes to DEPTH-1.
- Empty with wr=1 and rd=1: the write is accepted and the read is ignored; count goes to 1.
- Rejected requests change no state except the error flags.
- clr=1 has priority over wr and rd. Both pointers and count go to 0, and wr/rd in that cycle are discarded. Error flags are also cleared.
- Status outputs are pure decodes of the count register, so they have no combinational path from wr or rd.
- Pointers wrap from DEPTH-1 to 0. Full and empty are disambiguated by count, not by pointer equality.
- rst asserted mid-operation returns all state to reset values immediately, regardless of clk.

## Timing
- Write-to-read latency is 1 cycle. A word written at edge N appears on rdata, with empty=0, after edge N.
- rdata is combinational from mem[r_ptr]. After an accepted read at edge N, the next word is on rdata after edge N.
- count, flags and error bits update on the same edge as the accepted operation.
- No input is registered before use. wr, rd and clr must meet setup to clk.

## Configuration
- SYNC_FIFO_ERR_FLAG_EN defined: overflow sets on any cycle with wr=1 and full=1 (excluding clr cycles). underflow sets on any cycle with rd=1 and empty=1, excluding clr cycles and cycles where the read is ignored because a simultaneous write lands in an empty FIFO. Both flags hold until rst or clr.
- SYNC_FIFO_ERR_FLAG_EN not defined: overflow and underflow are tied to 0, with no flops inferred. The ports stay present so instantiations are identical.

## Structure
- Shared package fifo_pkg holds:
  - default DATA_WIDTH and ADDR_WIDTH constants;
  - count-width constant ADDR_WIDTH+1;
  - a parameter-legality check on AF_LEVEL and AE_LEVEL (elaboration error when out of range).
- Sub-module fifo_ram is a DEPTH x DATA_WIDTH register array with synchronous write and asynchronous read, parametrised on DATA_WIDTH and ADDR_WIDTH. Top-level drives its write enable with wr & ~full & ~clr.
- Pointer, count and flag logic live in the top level using two-process style (registered state plus next-state logic).

## Test plan
- Defaults (8-bit, DEPTH 16, AF 14, AE 2). Reset, then write 0x01..0x10 -> count=16, full=1, and almost_full=1 from count 14. A 17th write of 0xFF is dropped and overflow=1 (with macro). rdata stays 0x01.
- From full, read 16 times -> rdata sequence 0x01..0x10, then empty=1 and count=0. almost_empty=1 once count<=2. A 17th read sets underflow=1 (with macro), and pointers stay unchanged.
- Write 20 and read 20 interleaved, keeping occupancy 1..3 -> order preserved across pointer wrap, and count never exceeds 3.
- Simultaneous wr+rd when empty -> count=1 and rdata=wdata. Simultaneous wr+rd when full -> count=15 and the head advances. Simultaneous wr+rd at count=5 -> count stays 5.
- At count=7, assert clr together with wr=1 and rd=1 -> count=0, empty=1, flags cleared, and the written word discarded. The next write of 0xA5 appears on rdata after one edge.
- At count=9, assert rst asynchronously between edges -> all outputs take reset values before the next edge. Normal operation resumes after deassertion.
